// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle SISC control unit sequencing fetch, decode, execute, memory and writeback.
// Outputs are decoded from present state and inputs; memory waits stall in FETCH/MEM and trip FAULT on timeout.
module ctrl_mc #(
  parameter int OPW         = 4,
  parameter int ALUW        = 4,
  parameter int STATW       = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 5
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OPW-1:0]   opcode,
  input  logic [STATW-1:0] mm,
  input  logic [STATW-1:0] stat,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [ALUW-1:0]  alu_op,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_START0    = 4'd0,
    S_START1    = 4'd1,
    S_FETCH     = 4'd2,
    S_DECODE    = 4'd3,
    S_EXECUTE   = 4'd4,
    S_MEM       = 4'd5,
    S_WRITEBACK = 4'd6,
    S_HALT      = 4'd7,
    S_FAULT     = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_REG_OP = OPW'(1);
  localparam logic [OPW-1:0] OP_REG_IM = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA    = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR    = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE    = OPW'(6);
  localparam logic [OPW-1:0] OP_BNR    = OPW'(7);
  localparam logic [OPW-1:0] OP_LOD    = OPW'(10);
  localparam logic [OPW-1:0] OP_STR    = OPW'(11);
  localparam logic [OPW-1:0] OP_HLT    = OPW'(15);

  localparam logic [ALUW-1:0] ALU_REG_EX  = ALUW'(4'b0001);
  localparam logic [ALUW-1:0] ALU_IMM_EX  = ALUW'(4'b0011);
  localparam logic [ALUW-1:0] ALU_REG_MEM = ALUW'(4'b0000);
  localparam logic [ALUW-1:0] ALU_IMM_MEM = ALUW'(4'b0010);

  state_t          cur, nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;

  logic is_reg, is_imm, is_lod, is_str, is_mem, is_hlt, is_rel, legal;
  logic cond, taken, timeout;

  assign is_reg = (opcode == OP_REG_OP);
  assign is_imm = (opcode == OP_REG_IM);
  assign is_lod = (opcode == OP_LOD);
  assign is_str = (opcode == OP_STR);
  assign is_mem = is_lod || is_str;
  assign is_hlt = (opcode == OP_HLT);
  assign is_rel = (opcode == OP_BRR) || (opcode == OP_BNR);
  assign legal  = opcode inside {OP_NOOP, OP_REG_OP, OP_REG_IM, OP_BRA, OP_BRR,
                                 OP_BNE, OP_BNR, OP_LOD, OP_STR, OP_HLT};

  // An empty mask means "always"; BNE/BNR take the inverse sense.
  assign cond  = (mm == '0) || (|(stat & mm));
  assign taken = (((opcode == OP_BRA) || (opcode == OP_BRR)) && cond) ||
                 (((opcode == OP_BNE) || (opcode == OP_BNR)) && !cond);

  // Only consulted when mem_ready is low, so a ready at the limit still completes.
  assign timeout = (MEM_TIMEOUT > 0) && (cnt == CNTW'(MEM_TIMEOUT));

  assign state = cur;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cur <= S_START0;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;
    fault    = 1'b0;
    illegal  = 1'b0;
    case (cur)
      S_START0: nxt = S_START1;
      S_START1: nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        illegal = !legal;
        nxt     = is_hlt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_reg)
          alu_op = ALU_REG_EX;
        else if (is_imm || is_mem)
          alu_op = ALU_IMM_EX;
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = is_rel;
        end
        nxt = (is_reg || is_imm || is_mem) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        alu_op = is_reg ? ALU_REG_MEM : ALU_IMM_MEM;
        if (is_mem) begin
          mem_req = 1'b1;
          mem_we  = is_str;
          if (mem_ready)
            nxt = is_str ? S_FETCH : S_WRITEBACK;
          else if (timeout)
            nxt = S_FAULT;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we  = 1'b1;
        wb_sel = is_lod;
        nxt    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: nxt = S_START0;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (nxt != cur)
      cnt_nxt = '0;
    else if (mem_req && !mem_ready && (MEM_TIMEOUT > 0) && (cnt != {CNTW{1'b1}}))
      cnt_nxt = cnt + 1'b1;
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: a per-instruction trace model builds expected cycle-by-cycle outputs from the opcode rules.
module tb_ctrl_mc;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = '0, mm = '0, stat = '0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_write, pc_sel, br_sel, mem_req, mem_we, rf_we, wb_sel;
  logic [3:0] alu_op;
  logic       halted, fault, illegal;
  logic [3:0] state;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ctrl_mc #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .mem_req(mem_req), .mem_we(mem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted),
    .fault(fault), .illegal(illegal), .state(state)
  );

  typedef struct {
    logic        rdy;
    logic [3:0]  op;
    logic [3:0]  m;
    logic [3:0]  s;
    logic [16:0] v;
  } ent_t;

  ent_t tr[$];

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [16:0] mk(input logic [3:0] st, input logic irl, pcw, pcs, brs,
                                     input logic req, we, rfw, wbs, input logic [3:0] alu,
                                     input logic hal, flt, ill);
    return {irl, pcw, pcs, brs, req, we, rfw, wbs, alu, hal, flt, ill, st};
  endfunction

  function automatic logic [16:0] obs();
    return {ir_load, pc_write, pc_sel, br_sel, mem_req, mem_we, rf_we, wb_sel,
            alu_op, halted, fault, illegal, state};
  endfunction

  task automatic push(input logic rdy, input logic [3:0] op, m, s, input logic [16:0] v);
    ent_t e;
    e.rdy = rdy; e.op = op; e.m = m; e.s = s; e.v = v;
    tr.push_back(e);
  endtask

  task automatic drive(input ent_t e);
    mem_ready = e.rdy; opcode = e.op; mm = e.m; stat = e.s;
  endtask

  task automatic push_start();
    push(1'b1, r4(), r4(), r4(), mk(4'd0, 0,0,0,0, 0,0,0,0, 4'd0, 0,0,0));
    push(1'b1, r4(), r4(), r4(), mk(4'd1, 0,0,0,0, 0,0,0,0, 4'd0, 0,0,0));
  endtask

  task automatic push_fault();
    repeat (2) push(rb(), r4(), r4(), r4(), mk(4'd8, 0,0,0,0, 0,0,0,0, 4'd0, 0,1,0));
  endtask

  // Expected trace for one instruction: up to T waits are tolerated, one more faults.
  task automatic build_instr(input logic [3:0] op, m, s, input int fw, input int mw);
    logic cond, taken, rel, memop, regop, st;
    logic [3:0] alu;
    for (int i = 0; i < fw && i <= T; i++)
      push(1'b0, r4(), r4(), r4(), mk(4'd2, 0,0,0,0, 1,0,0,0, 4'd0, 0,0,0));
    if (fw > T) begin push_fault(); return; end
    push(1'b1, r4(), r4(), r4(), mk(4'd2, 1,1,0,0, 1,0,0,0, 4'd0, 0,0,0));
    push(rb(), op, m, s, mk(4'd3, 0,0,0,0, 0,0,0,0, 4'd0, 0,0,
         !(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15})));
    if (op == 4'd15) begin
      repeat (3) push(rb(), r4(), r4(), r4(), mk(4'd7, 0,0,0,0, 0,0,0,0, 4'd0, 1,0,0));
      return;
    end
    cond  = (m == 4'd0) || ((s & m) != 4'd0);
    taken = ((op == 4'd4 || op == 4'd5) && cond) || ((op == 4'd6 || op == 4'd7) && !cond);
    rel   = (op == 4'd5 || op == 4'd7);
    regop = (op == 4'd1 || op == 4'd2);
    memop = (op == 4'd10 || op == 4'd11);
    st    = (op == 4'd11);
    alu   = (op == 4'd1) ? 4'd1 : (op == 4'd2 || memop) ? 4'd3 : 4'd0;
    push(rb(), op, m, s, mk(4'd4, 0, taken, taken, taken & rel, 0,0,0,0, alu, 0,0,0));
    if (!regop && !memop) return;
    alu = (op == 4'd1) ? 4'd0 : 4'd2;
    if (regop) begin
      push(rb(), op, m, s, mk(4'd5, 0,0,0,0, 0,0,0,0, alu, 0,0,0));
    end else begin
      for (int i = 0; i < mw && i <= T; i++)
        push(1'b0, op, m, s, mk(4'd5, 0,0,0,0, 1,st,0,0, alu, 0,0,0));
      if (mw > T) begin push_fault(); return; end
      push(1'b1, op, m, s, mk(4'd5, 0,0,0,0, 1,st,0,0, alu, 0,0,0));
      if (st) return;
    end
    push(rb(), op, m, s, mk(4'd6, 0,0,0,0, 0,0,1, op == 4'd10, 4'd0, 0,0,0));
  endtask

  task automatic test_reset();
    rst_f = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (obs() !== 17'd0) begin failed++; $display("FAIL reset_hold got=%b exp=%b", obs(), 17'd0); end
    rst_f = 1'b1;
    tr.delete();
    push_start();
    build_instr(4'd0, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL reset_seq[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg_ops();
    tr.delete();
    build_instr(4'd2, r4(), r4(), 0, 0);
    build_instr(4'd1, r4(), r4(), 0, 0);
    build_instr(4'd0, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL reg_ops[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    tr.delete();
    build_instr(4'd5, 4'b0100, 4'b0100, 0, 0);
    build_instr(4'd6, 4'b0100, 4'b0100, 0, 0);
    build_instr(4'd4, 4'b0000, r4(), 0, 0);
    build_instr(4'd7, 4'b0000, r4(), 0, 0);
    build_instr(4'd4, 4'b0011, 4'b1100, 0, 0);
    build_instr(4'd7, 4'b0011, 4'b1100, 1, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL branch[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    tr.delete();
    build_instr(4'd10, r4(), r4(), 2, 3);
    build_instr(4'd11, r4(), r4(), 0, 3);
    build_instr(4'd10, r4(), r4(), T, T);
    build_instr(4'd11, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL load_store[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    tr.delete();
    build_instr(4'd3, r4(), r4(), 0, 0);
    build_instr(4'd8, r4(), r4(), 0, 0);
    build_instr(4'd12, r4(), r4(), 0, 0);
    build_instr(4'd0, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL illegal[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    tr.delete();
    for (int n = 0; n < 60; n++) begin
      do op = r4(); while (op == 4'd15);
      build_instr(op, r4(), r4(), $urandom_range(0, T), $urandom_range(0, T));
    end
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL random[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    tr.delete();
    build_instr(4'd15, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL halt[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
    #2 rst_f = 1'b0; #1;
    tests++;
    if (obs() !== 17'd0) begin failed++; $display("FAIL halt_reset got=%b exp=%b", obs(), 17'd0); end
    @(posedge clk); #1 rst_f = 1'b1;
    tr.delete();
    push_start();
    build_instr(4'd0, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL halt_recover[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    tr.delete();
    build_instr(4'd0, r4(), r4(), T + 1, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL fetch_timeout[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
    #2 rst_f = 1'b0; #1;
    tests++;
    if (obs() !== 17'd0) begin failed++; $display("FAIL fault_reset got=%b exp=%b", obs(), 17'd0); end
    @(posedge clk); #1 rst_f = 1'b1;
    tr.delete();
    push_start();
    build_instr(4'd11, r4(), r4(), 0, T + 1);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL mem_timeout[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  // Async reset while a load is waiting in MEM must drop mem_req at once.
  task automatic test_mid_reset();
    rst_f = 1'b0;
    @(posedge clk); #1 rst_f = 1'b1;
    tr.delete();
    push_start();
    build_instr(4'd10, r4(), r4(), 0, T + 1);
    for (int i = 0; i < 6; i++) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL mid_reset[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #2 rst_f = 1'b0; #1;
    tests++;
    if (obs() !== 17'd0) begin failed++; $display("FAIL mid_reset_drop got=%b exp=%b", obs(), 17'd0); end
    @(posedge clk); #1 rst_f = 1'b1;
    tr.delete();
    push_start();
    build_instr(4'd1, r4(), r4(), 0, 0);
    foreach (tr[i]) begin
      drive(tr[i]); @(negedge clk); tests++;
      if (obs() !== tr[i].v) begin failed++; $display("FAIL mid_recover[%0d] got=%b exp=%b", i, obs(), tr[i].v); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_reg_ops();
    test_branch();
    test_load_store();
    test_illegal();
    test_random();
    test_halt();
    test_timeout();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
